// File: rtl/hps_connection_write_data.sv
// hps_connection_write_data
//   FPGA-to-HPS return path. Fabric words enter a FIFO over a valid/ready
//   stream. The HPS drains them through a zero-wait-state Avalon-MM slave.
//   An optional level interrupt signals non-empty and/or overflow.
// Ports
//   clk, reset_n                    clock, asynchronous active-low reset
//   in_data/in_valid/in_ready       fabric push stream (in_ready = ~full)
//   address/chipselect/read_n/
//   write_n/writedata/readdata      Avalon slave s1, read latency 0
//   irq                             level interrupt to HPS
// Register map
//   0 DATA      head word, or 0 when empty. A read strobe pops the word.
//   1 STATUS    [15:0] count, [16] empty, [17] full, [18] overflow (W1C)
//   2 IRQ_MASK  [0] irq on non-empty, [1] irq on overflow
//   3 reserved
module hps_connection_write_data #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  read_n,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic                  irq
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [1:0]            mask_q, mask_d;

    logic empty, full, push, pop, wr_status, wr_mask, ovf_clr;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign in_ready = ~full;

    assign push      = in_valid & ~full;
    assign pop       = chipselect & ~read_n & (address == 2'd0) & ~empty;
    assign wr_status = chipselect & ~write_n & (address == 2'd1);
    assign wr_mask   = chipselect & ~write_n & (address == 2'd2);
    assign ovf_clr   = wr_status & writedata[18];

    // Only writedata[18] and [1:0] are meaningful; the remaining bits are
    // don't-care.
    logic unused_wdata;
    assign unused_wdata = ^{writedata[31:19], writedata[17:2]};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mask_d   = mask_q;
        // Pointers are log2(depth) wide, so the increment wraps by itself.
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A set in the same cycle takes priority over a clear.
        overflow_d = (in_valid & full) | (overflow_q & ~ovf_clr);
        if (wr_mask) mask_d = writedata[1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            mask_q     <= 2'b00;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            mask_q     <= mask_d;
        end
    end

    // Storage has no reset. Contents are only visible through count/rd_ptr.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    // Read mux is decoded by address alone, like the HPS-to-FPGA register.
    always_comb begin
        readdata = 32'h0;
        case (address)
            2'd0: if (!empty) readdata = 32'(mem_q[rd_ptr_q]);
            2'd1: begin
                readdata[15:0] = 16'(count_q);
                readdata[16]   = empty;
                readdata[17]   = full;
                readdata[18]   = overflow_q;
            end
            2'd2:    readdata[1:0] = mask_q;
            default: readdata = 32'h0;
        endcase
    end

    assign irq = (mask_q[0] & ~empty) | (mask_q[1] & overflow_q);

endmodule

// File: tb/tb_hps_connection_write_data.sv
module tb_hps_connection_write_data;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    // Reference model: a queue of words plus the sticky flag and the mask.
    logic [31:0] q[$];
    logic        m_ovf;
    logic [1:0]  m_mask;

    hps_connection_write_data #(.DATA_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .address(address), .chipselect(chipselect), .read_n(read_n),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        logic [31:0] r;
        r = 32'h0;
        if (a == 2'd0) begin
            if (q.size() > 0) r = q[0];
        end else if (a == 2'd1) begin
            r[15:0] = 16'(q.size());
            r[16]   = (q.size() == 0);
            r[17]   = (q.size() == DEPTH);
            r[18]   = m_ovf;
        end else if (a == 2'd2) begin
            r[1:0] = m_mask;
        end
        return r;
    endfunction

    function automatic logic exp_irq();
        return (m_mask[0] && q.size() > 0) || (m_mask[1] && m_ovf);
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_mask = 2'b00;
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        in_data    = 32'h0;
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = 32'h0;
    endtask

    // Advance one clock edge and update the model using the current inputs.
    task automatic tick();
        bit do_push, do_pop, clr;
        do_push = in_valid && (q.size() < DEPTH);
        do_pop  = chipselect && !read_n && address == 2'd0 && q.size() > 0;
        clr     = chipselect && !write_n && address == 2'd1 && writedata[18];
        @(posedge clk);
        if (in_valid && q.size() == DEPTH) m_ovf = 1'b1;
        else if (clr)                      m_ovf = 1'b0;
        if (chipselect && !write_n && address == 2'd2) m_mask = writedata[1:0];
        if (do_pop)  void'(q.pop_front());
        if (do_push) q.push_back(in_data);
        #1;
        idle();
    endtask

    task automatic push_word(input logic [31:0] w);
        in_valid = 1'b1;
        in_data  = w;
        tick();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick();
    endtask

    // Read a register, compare against the model, and perform the strobe.
    task automatic bus_read(input logic [1:0] a, input string name);
        logic [31:0] e;
        chipselect = 1'b1; read_n = 1'b0; address = a;
        #1;
        e = exp_rd(a);
        checks++;
        if (readdata !== e) begin
            failures++;
            $display("FAIL %s: readdata=%h expected=%h", name, readdata, e);
        end
        tick();
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: in_ready=%b irq=%b expected 1/0", in_ready, irq);
        end
        address = 2'd1; #1;
        checks++;
        if (readdata !== 32'h0001_0000) begin
            failures++;
            $display("FAIL reset_status: got=%h expected=00010000", readdata);
        end
        idle();
    endtask

    task automatic test_order();
        push_word(32'h11); push_word(32'h22); push_word(32'h33);
        bus_read(2'd1, "order_status3");
        checks++;
        if (exp_rd(2'd1) !== 32'h3) begin
            failures++;
            $display("FAIL order_model: model status=%h expected=00000003", exp_rd(2'd1));
        end
        chipselect = 1'b1; read_n = 1'b0; address = 2'd0; #1;
        checks++;
        if (readdata !== 32'h11) begin
            failures++;
            $display("FAIL order_first: got=%h expected=00000011", readdata);
        end
        tick();
        bus_read(2'd0, "order_second");
        bus_read(2'd0, "order_third");
        bus_read(2'd1, "order_empty_status");
    endtask

    task automatic test_fill_wrap();
        for (int i = 0; i < DEPTH; i++) push_word($urandom);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_ready: in_ready=%b expected=0", in_ready);
        end
        address = 2'd1; #1;
        checks++;
        if (readdata !== 32'h0002_0008) begin
            failures++;
            $display("FAIL full_status: got=%h expected=00020008", readdata);
        end
        push_word(32'hDEAD_BEEF);          // lost, sets overflow
        bus_read(2'd1, "overflow_status");
        bus_write(2'd1, 32'h0004_0000);
        bus_read(2'd1, "overflow_cleared");
        for (int i = 0; i < 3; i++) bus_read(2'd0, "wrap_pop");
        for (int i = 0; i < 3; i++) push_word($urandom);
        for (int i = 0; i < DEPTH; i++) bus_read(2'd0, "wrap_order");
        bus_read(2'd1, "wrap_empty");
    endtask

    task automatic test_simultaneous();
        logic [31:0] last;
        for (int i = 0; i < 4; i++) push_word(32'h100 + i);
        in_valid = 1'b1; in_data = 32'hAA;
        bus_read(2'd0, "simul_head");
        address = 2'd1; #1;
        checks++;
        if (readdata !== 32'h4) begin
            failures++;
            $display("FAIL simul_count: got=%h expected=00000004", readdata);
        end
        idle();
        for (int i = 0; i < 3; i++) bus_read(2'd0, "simul_drain");
        chipselect = 1'b1; read_n = 1'b0; address = 2'd0; #1;
        last = readdata;
        checks++;
        if (last !== 32'hAA) begin
            failures++;
            $display("FAIL simul_last: got=%h expected=000000aa", last);
        end
        tick();
    endtask

    task automatic test_irq();
        bus_write(2'd2, 32'h1);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_empty: irq=%b expected=0", irq);
        end
        push_word(32'h5);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_nonempty: irq=%b expected=1", irq);
        end
        bus_read(2'd0, "irq_pop");
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_popped: irq=%b expected=0", irq);
        end
        bus_write(2'd2, 32'h2);
        for (int i = 0; i < DEPTH + 1; i++) push_word($urandom);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_overflow: irq=%b expected=1", irq);
        end
        bus_write(2'd1, 32'h0004_0000);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_ovf_cleared: irq=%b expected=0", irq);
        end
        for (int i = 0; i < DEPTH; i++) bus_read(2'd0, "irq_drain");
    endtask

    task automatic test_edge();
        bus_read(2'd0, "empty_data_read");
        bus_read(2'd1, "empty_count_stays");
        bus_write(2'd2, 32'h3);
        for (int i = 0; i < 5; i++) push_word($urandom);
        reset_n = 1'b0; #1;
        model_reset();
        checks++;
        if (in_ready !== 1'b1 || irq !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_flags: in_ready=%b irq=%b expected 1/0", in_ready, irq);
        end
        address = 2'd1; #1;
        checks++;
        if (readdata !== 32'h0001_0000) begin
            failures++;
            $display("FAIL async_reset_status: got=%h expected=00010000", readdata);
        end
        address = 2'd2; #1;
        checks++;
        if (readdata !== 32'h0) begin
            failures++;
            $display("FAIL async_reset_mask: got=%h expected=00000000", readdata);
        end
        idle();
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        push_word(32'h77);
        bus_read(2'd3, "addr3_reads_zero");
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd0, "after_reset_data");
    endtask

    task automatic test_random();
        int op;
        for (int n = 0; n < 400; n++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = $urandom;
            op = $urandom_range(0, 6);
            case (op)
                2, 3: begin chipselect = 1'b1; read_n = 1'b0; address = 2'd0; end
                4: begin chipselect = 1'b1; read_n = 1'b0; address = 2'd1; end
                5: begin chipselect = 1'b1; write_n = 1'b0; address = 2'd1; writedata = $urandom; end
                6: begin chipselect = 1'b1; write_n = 1'b0; address = 2'd2; writedata = $urandom; end
                default: address = 2'($urandom_range(0, 3));
            endcase
            #1;
            checks++;
            if (readdata !== exp_rd(address) || irq !== exp_irq() ||
                in_ready !== (q.size() < DEPTH)) begin
                failures++;
                $display("FAIL random[%0d]: rd=%h exp=%h irq=%b exp=%b rdy=%b size=%0d",
                         n, readdata, exp_rd(address), irq, exp_irq(), in_ready, q.size());
            end
            tick();
        end
    endtask

    initial begin
        idle();
        model_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_order();
        test_fill_wrap();
        test_simultaneous();
        test_irq();
        test_edge();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
